// File: rtl/seq_srl8.sv
// seq_srl8: iterative right shifter, one bit per clock, start/busy/done handshake.
// Optional arithmetic fill is enabled by defining SEQ_SRL8_SRA_EN.
module seq_srl8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             arith,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] C
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_MAX = CW'(WIDTH);
    localparam logic [WIDTH-1:0] B_SAT   = WIDTH'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] w_sreg_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [CW-1:0]    w_cnt_load;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [WIDTH-1:0] r_c;
    logic [WIDTH-1:0] w_c_nxt;
    logic             w_accept;
    logic             w_fill;

    assign w_accept = (r_state == S_IDLE) && start;

    // Amounts at or beyond the data width collapse to a full-width shift.
    assign w_cnt_load = (B >= B_SAT) ? CNT_MAX : B[CW-1:0];

`ifdef SEQ_SRL8_SRA_EN
    logic r_mode;

    // Shift mode is captured alongside the operands.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mode <= 1'b0;
        end else if (w_accept) begin
            r_mode <= arith;
        end else begin
            r_mode <= r_mode;
        end
    end

    assign w_fill = r_mode & r_sreg[WIDTH-1];
`else
    logic w_arith_unused;

    assign w_arith_unused = arith;
    assign w_fill         = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-datapath decode.
    always_comb begin
        w_state_nxt = r_state;
        w_sreg_nxt  = r_sreg;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_c_nxt     = r_c;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_sreg_nxt  = A;
                    w_cnt_nxt   = w_cnt_load;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (r_cnt != {CW{1'b0}}) begin
                    w_sreg_nxt = {w_fill, r_sreg[WIDTH-1:1]};
                    w_cnt_nxt  = r_cnt - CW'(1);
                end else begin
                    w_c_nxt     = r_sreg;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath and output registers; reset discards any in-flight work.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sreg <= {WIDTH{1'b0}};
            r_cnt  <= {CW{1'b0}};
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_c    <= {WIDTH{1'b0}};
        end else begin
            r_sreg <= w_sreg_nxt;
            r_cnt  <= w_cnt_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            r_c    <= w_c_nxt;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign C    = r_c;

endmodule

// File: doc/seq_srl8.md
Name: seq_srl8

Overview:
- Iterative (multi-cycle) logical shift-right unit, one bit per clock; the right-shift counterpart of the 8-bit combinational SLL8 shifter in the ALU datapath.
- Operand A is shifted right by the amount in B. Operation uses a start/busy/done handshake.
- Sits beside the combinational shifters as the area-cheap right-shift option for the sequential datapath.

Parameters:
- WIDTH, 8, data width of A, B and C. Shift amounts >= WIDTH saturate to WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset.
- start  input  1  request. Sampled only in IDLE.
- A  input  WIDTH  operand. Latched when start is accepted.
- B  input  WIDTH  shift amount (unsigned, full width). Latched when start is accepted.
- arith  input  1  arithmetic-shift select. Latched with A/B. Functional only with SRA_EN; otherwise ignored.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when C becomes valid.
- C  output  WIDTH  result. Holds until the next accepted start or reset.

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE; busy=0, done=0, C=0; internal count and shift register cleared. Reset takes priority over everything, including mid-operation; an in-flight result is discarded.
- State machine has three states: IDLE, SHIFT, DONE.
- IDLE:
  - start==1: latch sreg=A, cnt=min(B,WIDTH), mode=arith; go to SHIFT; busy=1.
  - start==0: stay in IDLE.
- SHIFT, cnt!=0: sreg shifts right by 1 with fill bit 0 (or per Optional Feature); cnt decrements.
- SHIFT, cnt==0: C=sreg, done=1, busy=0; go to DONE.
- DONE: done=0; go to IDLE. A start in the DONE cycle is ignored. The earliest next accept is the cycle after DONE.
- start while busy: ignored, no effect on the in-flight operation.
- Latency, with n=min(B,WIDTH) and the accept edge counted as edge 0:
  - done rises after edge n+1; C updates on that same edge.
  - busy is high from after edge 0 until edge n+1.
  - Throughput: one operation per n+3 cycles.
- B >= WIDTH (e.g. 8'd98): cnt=WIDTH, so the result is all fill bits (0 for a logical shift). Latency is WIDTH+1.
- B==0: C=A. done rises after edge 1.
- C is stable between done pulses; changes only on a done edge or on reset.
- A and B may change freely after the accept edge without affecting the result.

Optional Feature:
- Macro: SEQ_SRL8_SRA_EN.
- Defined: when the latched mode==1, the fill bit is the current sreg MSB (arithmetic right shift). Saturated shifts yield all copies of A[WIDTH-1]. When mode==0, behaviour is a logical shift.
- Undefined: the arith input is unconnected internally; every operation is a logical shift; the fill bit is always 0.

Test Plan:
- Reset: rst=0 for 2 cycles with start=1 -> busy=0, done=0, C=8'h00. No operation starts while rst=0.
- A=8'b10110101, B=0, start pulse -> done after edge 1, C=8'b10110101, busy high for exactly 1 cycle.
- A=8'b10110101, B=3 -> C=8'b00010110, done after edge 4. With B=7 -> C=8'b00000001, done after edge 8.
- A=8'b10110101, B=8'b01100010 (98) -> C=8'h00, done after edge 9. With SEQ_SRL8_SRA_EN and arith=1 -> C=8'hFF.
- SRA_EN, arith=1, A=8'b10110101, B=3 -> C=8'b11110110. Same with arith=0 -> C=8'b00010110.
- Start B=5, then mid-shift pulse start with B=1 -> ignored, C=8'b00000101 at edge 6. Repeat and drive rst=0 at edge 3 -> busy=0, C=0, no done pulse.
